fetch_decode_queue: RTL and testbench

Parametrised fetch-to-decode buffer that supersedes the single-entry fetch/decode pipeline register. It holds up to DEPTH fetched instruction bundles (instruction, PC, PC+4, branch-prediction bit) in a circular queue with a valid/ready handshake on both sides. It sits between the fetch stage (PC/BTB/instruction memory) and decode, and supports a synchronous flush on branch redirect. Empty-queue slots present a zero bundle to decode, so decode sees a NOP bubble.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fdq_ptr_ctrl.sv | 68 ++++++
 rtl/fetch_decode_queue.sv | 79 +++++++
 tb/tb_fetch_decode_queue.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: bundle type, NOP constant and sizing helper shared by the fetch/decode queue.
`default_nettype none

package fetch_pkg;

  localparam int FETCH_DATA_W = 32;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_DATA_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] pc_plus_four;
    logic                    predict_jump;
  } fetch_bundle_t;

  localparam fetch_bundle_t NOP_BUNDLE = '0;

  function automatic int fdq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fdq_ptr_ctrl.sv
// fdq_ptr_ctrl: head/tail/count registers of the fetch-decode queue with push, pop and flush.
`default_nettype none

module fdq_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_req_i,
  input  logic             pop_req_i,
  output logic [PTR_W-1:0] head_o,
  output logic [PTR_W-1:0] tail_o,
  output logic             push_o,
  output logic             in_ready_o,
  output logic             eff_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // Handshake flags come only from the registered count, so a same-cycle pop
  // never opens a slot for a push while full.
  assign in_ready_o = (count_q != CNT_W'(DEPTH));
  assign eff_o      = (count_q != '0);
  assign push       = push_req_i & in_ready_o & ~clr_i;
  assign pop        = pop_req_i & eff_o & ~clr_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clr_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign push_o  = push;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: DEPTH-entry circular buffer of fetched bundles between fetch and decode.
`default_nettype none

module fetch_decode_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLR,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [DATA_W-1:0]        Instr,
  input  logic [DATA_W-1:0]        PC,
  input  logic [DATA_W-1:0]        PC_plus_four,
  input  logic                     PredictJump,
  output logic                     Eff,
  input  logic                     Out_Ready,
  output logic [DATA_W-1:0]        Instr_Out,
  output logic [DATA_W-1:0]        PC_Out,
  output logic [DATA_W-1:0]        PC_plus_four_Out,
  output logic                     PredictJump_Out,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fdq_cnt_w(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus_four;
    logic              predict_jump;
  } bundle_t;

  bundle_t          mem_q [DEPTH];
  bundle_t          in_bundle;
  bundle_t          head_bundle;
  logic [PTR_W-1:0] head, tail;
  logic             push;

  fdq_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ptr_ctrl (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (CLR),
    .push_req_i (In_Valid),
    .pop_req_i  (Out_Ready),
    .head_o     (head),
    .tail_o     (tail),
    .push_o     (push),
    .in_ready_o (In_Ready),
    .eff_o      (Eff),
    .count_o    (Count)
  );

  assign in_bundle = '{instr: Instr, pc: PC, pc_plus_four: PC_plus_four,
                       predict_jump: PredictJump};

  // Storage is never reset or cleared; occupancy alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (push) mem_q[tail] <= in_bundle;
  end

  // An empty queue shows an all-zero bundle so decode executes a NOP bubble.
  assign head_bundle      = Eff ? mem_q[head] : '0;
  assign Instr_Out        = head_bundle.instr;
  assign PC_Out           = head_bundle.pc;
  assign PC_plus_four_Out = head_bundle.pc_plus_four;
  assign PredictJump_Out  = head_bundle.predict_jump;

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed and random checks of fetch_decode_queue against a queue model.
`default_nettype none

module tb_fetch_decode_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST, CLR, In_Valid, In_Ready, PredictJump, Eff, Out_Ready, PredictJump_Out;
  logic [31:0] Instr, PC, PC_plus_four, Instr_Out, PC_Out, PC_plus_four_Out;
  logic [2:0]  Count;

  int n_assert = 0;
  int n_fail   = 0;
  fetch_bundle_t model [$];

  fetch_decode_queue #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Instr(Instr), .PC(PC), .PC_plus_four(PC_plus_four), .PredictJump(PredictJump),
    .Eff(Eff), .Out_Ready(Out_Ready), .Instr_Out(Instr_Out), .PC_Out(PC_Out),
    .PC_plus_four_Out(PC_plus_four_Out), .PredictJump_Out(PredictJump_Out), .Count(Count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    fetch_bundle_t h;
    h = (model.size() != 0) ? model[0] : NOP_BUNDLE;
    chk({tag, ".count"},    64'(Count),           64'(model.size()));
    chk({tag, ".eff"},      64'(Eff),             64'(model.size() != 0));
    chk({tag, ".in_ready"}, 64'(In_Ready),        64'(model.size() != DEPTH));
    chk({tag, ".instr"},    64'(Instr_Out),       64'(h.instr));
    chk({tag, ".pc"},       64'(PC_Out),          64'(h.pc));
    chk({tag, ".pc4"},      64'(PC_plus_four_Out), 64'(h.pc_plus_four));
    chk({tag, ".pj"},       64'(PredictJump_Out), 64'(h.predict_jump));
  endtask

  task automatic drive(input logic v, input logic r, input logic c,
                       input logic [31:0] pc, input logic pj);
    In_Valid     = v;
    Out_Ready    = r;
    CLR          = c;
    Instr        = $urandom;
    PC           = pc;
    PC_plus_four = pc + 32'd4;
    PredictJump  = pj;
  endtask

  // Advance one clock edge, apply the queue rules to the model, then check.
  task automatic cycle(input string tag);
    bit do_push, do_pop;
    fetch_bundle_t b;
    do_push = In_Valid && (model.size() != DEPTH) && !CLR;
    do_pop  = Out_Ready && (model.size() != 0) && !CLR;
    b = '{instr: Instr, pc: PC, pc_plus_four: PC_plus_four, predict_jump: PredictJump};
    @(posedge CLK);
    if (CLR) model.delete();
    else begin
      if (do_pop)  void'(model.pop_front());
      if (do_push) model.push_back(b);
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    RST = 1'b1;
    drive(0, 0, 0, 32'h0, 0);
    repeat (2) @(posedge CLK);
    #1;
    check_model("reset");
    RST = 1'b0;
    cycle("post_reset");

    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 32'(i * 4), 1'(i % 2));
      cycle("fill");
    end
    chk("fill.count4", 64'(Count), 64'd4);
    chk("fill.not_ready", 64'(In_Ready), 64'd0);
    drive(1, 0, 0, 32'h10, 0);
    cycle("refused");
    chk("refused.count4", 64'(Count), 64'd4);

    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 32'h0, 0);
      chk("drain.pc_seq", 64'(PC_Out), 64'(i * 4));
      cycle("drain");
    end
    chk("drain.eff0", 64'(Eff), 64'd0);
    chk("drain.pc0", 64'(PC_Out), 64'd0);

    for (int i = 0; i < 12; i++) begin
      drive(1, 1, 0, 32'h100 + 32'(i * 4), 1'(i % 2 == 0));
      cycle("stream");
      chk("stream.count1", 64'(Count), 64'd1);
      chk("stream.pc", 64'(PC_Out), 64'h100 + 64'(i * 4));
      chk("stream.pj", 64'(PredictJump_Out), 64'(i % 2 == 0));
    end
    drive(0, 1, 0, 32'h0, 0);
    cycle("stream_drain");

    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 32'h180 + 32'(i * 4), 0);
      cycle("refill");
    end
    drive(1, 1, 0, 32'h200, 1);
    cycle("full_pushpop");
    chk("full_pushpop.count3", 64'(Count), 64'd3);
    cycle("full_pushpop_next");
    chk("full_pushpop_next.count3", 64'(Count), 64'd3);

    drive(1, 1, 1, 32'h300, 0);
    cycle("flush");
    chk("flush.count0", 64'(Count), 64'd0);
    chk("flush.instr0", 64'(Instr_Out), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 32'h340, 1);
      cycle("flush_hold");
      chk("flush_hold.ready", 64'(In_Ready), 64'd1);
    end
    drive(0, 0, 0, 32'h0, 0);
    cycle("after_flush");

    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 32'h20 + 32'(i * 4), 0);
      cycle("pre_arst");
    end
    drive(0, 0, 0, 32'h0, 0);
    #2;
    RST = 1'b1;
    #1;
    chk("arst.eff0", 64'(Eff), 64'd0);
    chk("arst.count0", 64'(Count), 64'd0);
    chk("arst.ready", 64'(In_Ready), 64'd1);
    model.delete();
    #1;
    RST = 1'b0;
    drive(1, 0, 0, 32'h40, 0);
    cycle("after_arst");
    chk("after_arst.pc40", 64'(PC_Out), 64'h40);
    chk("after_arst.count1", 64'(Count), 64'd1);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0), $urandom, 1'($urandom_range(0, 1)));
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
